// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: the pipeline writeback always owns the port; long-unit results wait in a small
// FIFO and drain into free slots. Optional macro LU_BYPASS_EN writes a long-unit result straight through when idle.
module regfile_wb_arbiter #(
   parameter int XLEN         = 32,
   parameter int Q_DEPTH      = 2,
   parameter int STARVE_LIMIT = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            pipe_wb_en,
   input  logic [4:0]      pipe_wb_rd,
   input  logic [XLEN-1:0] pipe_wb_data,
   input  logic            lu_valid,
   output logic            lu_ready,
   input  logic [4:0]      lu_rd,
   input  logic [XLEN-1:0] lu_data,
   input  logic            issue_en,
   input  logic [4:0]      issue_rd,
   input  logic [4:0]      id_rs1,
   input  logic [4:0]      id_rs2,
   output logic            hazard,
   output logic            pipe_stall,
   output logic            rf_we,
   output logic [4:0]      rf_rd,
   output logic [XLEN-1:0] rf_wdata
);

   localparam int AW = $clog2(Q_DEPTH);
   localparam int CW = $clog2(Q_DEPTH + 1);
   localparam int SW = $clog2(STARVE_LIMIT + 1);
   localparam logic [CW-1:0] Q_FULL = CW'(Q_DEPTH);
   localparam logic [SW-1:0] S_MAX  = SW'(STARVE_LIMIT);

   logic [4:0]      q_rd   [Q_DEPTH];
   logic [XLEN-1:0] q_data [Q_DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [CW-1:0]   count;
   logic [CW-1:0]   count_nxt;
   logic            ready_q;
   logic [31:0]     busy;
   logic [31:0]     busy_nxt;
   logic [31:0]     set_vec;
   logic [31:0]     clr_vec;
   logic [31:0]     hazard_vec;
   logic [SW-1:0]   starve;
   logic [SW-1:0]   starve_nxt;

   logic            pipe_busy;
   logic            q_empty;
   logic            pop;
   logic            push;
   logic            bypass;
   logic            bypass_we;
   logic            lu_wr;
   logic [4:0]      lu_wr_rd;
   logic [XLEN-1:0] lu_wr_data;

   always_comb begin
      pipe_busy = pipe_wb_en && (pipe_wb_rd != 5'd0);
      q_empty   = (count == '0);
      pop       = !pipe_busy && !q_empty;
`ifdef LU_BYPASS_EN
      bypass    = rst_n && !pipe_busy && q_empty && lu_valid;
`else
      bypass    = 1'b0;
`endif
      // x0 results complete the handshake but are never stored or written
      push       = lu_valid && ready_q && !bypass && (lu_rd != 5'd0);
      bypass_we  = bypass && (lu_rd != 5'd0);
      lu_wr      = pop || bypass_we;
      lu_wr_rd   = pop ? q_rd[rd_ptr]   : lu_rd;
      lu_wr_data = pop ? q_data[rd_ptr] : lu_data;
      count_nxt  = count + CW'(push) - CW'(pop);
   end

   // Combinational outputs are gated by rst_n so they fall the instant reset asserts.
   always_comb begin
      rf_we    = 1'b0;
      rf_rd    = 5'd0;
      rf_wdata = '0;
      if (rst_n) begin
         if (pipe_busy) begin
            rf_we    = 1'b1;
            rf_rd    = pipe_wb_rd;
            rf_wdata = pipe_wb_data;
         end else if (lu_wr) begin
            rf_we    = 1'b1;
            rf_rd    = lu_wr_rd;
            rf_wdata = lu_wr_data;
         end
      end
      lu_ready = ready_q || bypass;
   end

   always_comb begin
      set_vec  = '0;
      clr_vec  = '0;
      if (issue_en && (issue_rd != 5'd0)) set_vec = 32'd1 << issue_rd;
      if (lu_wr) clr_vec = 32'd1 << lu_wr_rd;
      busy_nxt = ((busy & ~clr_vec) | set_vec) & ~32'd1;
      // A same-cycle re-issue keeps the register pending, so the forwarded write does not release ID
      hazard_vec = busy & ~(clr_vec & ~set_vec);
      hazard     = rst_n && (hazard_vec[id_rs1] || hazard_vec[id_rs2]);
   end

   always_comb begin
      if (q_empty || pop)     starve_nxt = '0;
      else if (starve == S_MAX) starve_nxt = starve;
      else                      starve_nxt = starve + SW'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         ready_q    <= 1'b0;
         busy       <= '0;
         starve     <= '0;
         pipe_stall <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         count      <= count_nxt;
         ready_q    <= (count_nxt < Q_FULL);
         busy       <= busy_nxt;
         starve     <= starve_nxt;
         pipe_stall <= (starve_nxt == S_MAX);
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         q_rd[wr_ptr]   <= lu_rd;
         q_data[wr_ptr] <= lu_data;
      end
   end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Shares the single register-file write port between the in-order pipeline writeback and a long-latency unit (mul/div/load miss).
- Pipeline writeback always wins.
- Long-unit results are buffered in a small queue and drained into free writeback slots.
- A destination scoreboard drives an ID-stage hazard flag.
- A starvation counter requests pipeline bubbles so queued results cannot wait forever.
- Sits between the WB stage, the long unit and the register file's write port.

Parameters:
XLEN, 32, data width
Q_DEPTH, 2, long-unit result queue entries (power of two, >=2)
STARVE_LIMIT, 4, consecutive undrained cycles before pipe_stall asserts

Ports:
clk  in  1  clock
rst_n  in  1  reset; asynchronous, active-low
pipe_wb_en  in  1  pipeline writeback valid
pipe_wb_rd  in  5  pipeline destination register
pipe_wb_data  in  XLEN  pipeline writeback data
lu_valid  in  1  long-unit result valid
lu_ready  out  1  queue can accept a long-unit result
lu_rd  in  5  long-unit destination register
lu_data  in  XLEN  long-unit result data
issue_en  in  1  long-unit op issued this cycle
issue_rd  in  5  destination of issued op
id_rs1  in  5  ID-stage source register 1
id_rs2  in  5  ID-stage source register 2
hazard  out  1  ID must stall (source pending in long unit)
pipe_stall  out  1  request front-end bubble
rf_we  out  1  register-file write enable
rf_rd  out  5  register-file write address
rf_wdata  out  XLEN  register-file write data

Behaviour:
- Reset (async, rst_n low):
  - Queue empty, count=0, scoreboard clear, starvation counter=0.
  - lu_ready=0, pipe_stall=0, hazard=0, rf_we=0, rf_rd=0, rf_wdata=0.
  - lu_ready rises the first cycle after rst_n deasserts.
  - Reset mid-operation discards queued results; no writes are issued for them.
- Pipe slot:
  - Busy when pipe_wb_en=1 and pipe_wb_rd!=0. Free otherwise.
  - Busy: rf_we=1, rf_rd=pipe_wb_rd, rf_wdata=pipe_wb_data.
  - Free and queue non-empty: head entry drives the port (rf_we=1) and is popped at the clock edge.
  - Free and queue empty: rf_we=0 (see optional feature for bypass).
- Write port is combinational (zero added latency). The register file's internal WB->ID forwarding covers same-cycle reads.
- Queue:
  - Registered FIFO. lu_ready = (count < Q_DEPTH), registered/derived only from count.
  - No same-cycle pass-through when full.
  - Push when lu_valid && lu_ready.
  - Results with lu_rd=0 are accepted and dropped (never written, never counted).
  - Push and pop in the same cycle: count unchanged, order preserved.
  - Pointers wrap modulo Q_DEPTH.
- Scoreboard (busy[31:1]; x0 never busy):
  - Set: issue_en && issue_rd!=0 sets busy[issue_rd].
  - Clear: busy[r] clears when a long-unit entry with rd=r is written to rf.
  - Set and clear of the same r in one cycle: set wins.
- hazard:
  - hazard = (busy[id_rs1] && not being written by long unit this cycle) || (same for id_rs2).
  - Combinational.
- Starvation:
  - Counter increments each cycle the queue is non-empty and nothing is popped.
  - Clears on any pop or when the queue is empty; saturates at STARVE_LIMIT.
  - pipe_stall = (counter == STARVE_LIMIT), registered. Drops the cycle after the pop.
- Pipeline writeback to a busy register is a pipeline contract violation and is not checked.

Optional Feature:
Macro: LU_BYPASS_EN
- Defined: when the queue is empty, the pipe slot is free and lu_valid=1, lu_data is written directly the same cycle.
  - lu_ready is 1 in this case even if count logic would say otherwise.
  - No push occurs.
  - The scoreboard clears as for a pop.
- Undefined: every long-unit result passes through the queue, giving a minimum 1-cycle write latency.

Test Plan:
1. Queue empty, pipe_wb_en=0, lu_valid=1, lu_rd=5, lu_data=0xDEADBEEF:
   - Without LU_BYPASS_EN: rf_we=1, rf_rd=5, rf_wdata=0xDEADBEEF one cycle later.
   - With LU_BYPASS_EN: same values in the same cycle.
2. pipe_wb_en=1 continuously (rd=3, data=0x11) while lu pushes rd=7 and rd=8:
   - rf always shows rd=3.
   - lu_ready=0 after 2 pushes.
   - pipe_stall=1 after 4 undrained cycles.
   - Drop pipe_wb_en: rd=7 then rd=8 written in order, pipe_stall clears.
3. issue_en, issue_rd=9; id_rs1=9 -> hazard=1 every cycle.
   - Cycle the rd=9 result is written: hazard=0 (forwarded).
   - busy[9]=0 afterwards.
4. Same cycle: issue_rd=9 and queue head rd=9 drained -> busy[9] remains 1, hazard stays 1 for id_rs2=9.
5. lu_rd=0 push -> no rf write, count unchanged, lu_ready stays 1.
   - issue_rd=0 -> hazard never set for id_rs1=0.
6. Queue holding 2 entries, pipe_stall=1, assert rst_n=0 asynchronously mid-cycle:
   - All outputs 0 immediately.
   - After release, no stale writes; lu_ready=1 next cycle.
